// File: rtl/retro_catc_multi_if.sv
//------------------------------------------------------------------------------
// retro_catc_multi_if
// Bundles the rate, control and status signals of the multi-channel timing
// controller.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface retro_catc_multi_if #(
    parameter int Channels  = 2,
    parameter int AccWidth  = 32,
    parameter int DebtWidth = 8
);
    logic [Channels*AccWidth-1:0]  Increment;
    logic [Channels-1:0]           Enable;
    logic                          Delay;
    logic [Channels-1:0]           CatchUp;
    logic [Channels-1:0]           ClearOverrun;
    logic [Channels-1:0]           ClkEnOut;
    logic [Channels*DebtWidth-1:0] Debt;
    logic [Channels-1:0]           Overrun;

    modport master (
        output Increment, Enable, Delay, CatchUp, ClearOverrun,
        input  ClkEnOut, Debt, Overrun
    );

    modport slave (
        input  Increment, Enable, Delay, CatchUp, ClearOverrun,
        output ClkEnOut, Debt, Overrun
    );
endinterface

`default_nettype wire

// File: rtl/retro_catc_multi.sv
//------------------------------------------------------------------------------
// retro_catc_multi
// Generates independent fractional-rate clock-enable streams from the core
// clock, with a shared stall, per-channel tick debt and catch-up bursts.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module retro_catc_multi #(
    parameter int Channels  = 2,
    parameter int AccWidth  = 32,
    parameter int DebtWidth = 8
) (
    input wire Clk,
    input wire Reset,
    retro_catc_multi_if.slave bus
);

    localparam logic [DebtWidth-1:0] c_debtMax = '1;
    localparam logic [DebtWidth-1:0] c_debtOne = DebtWidth'(1);

    logic [Channels-1:0][AccWidth-1:0]  r_acc;
    logic [Channels-1:0][AccWidth-1:0]  w_accNext;
    logic [Channels-1:0][DebtWidth-1:0] r_debt;
    logic [Channels-1:0][DebtWidth-1:0] w_debtNext;
    logic [Channels-1:0][AccWidth:0]    w_sum;
    logic [Channels-1:0]                r_clkEn;
    logic [Channels-1:0]                r_overrun;
    logic [Channels-1:0]                w_overrunNext;
    logic [Channels-1:0]                w_tick;
    logic [Channels-1:0]                w_emit;

    always_comb begin
        w_sum         = '0;
        w_tick        = '0;
        w_emit        = '0;
        w_accNext     = r_acc;
        w_debtNext    = r_debt;
        w_overrunNext = r_overrun;
        for (int i = 0; i < Channels; i++) begin
            w_sum[i]  = {1'b0, r_acc[i]} + {1'b0, bus.Increment[i*AccWidth +: AccWidth]};
            w_tick[i] = bus.Enable[i] & w_sum[i][AccWidth];
            w_emit[i] = bus.Enable[i] & ~bus.Delay &
                        (w_tick[i] | (bus.CatchUp[i] & (r_debt[i] != '0)));
            // A disabled channel freezes both its phase and its debt.
            if (bus.Enable[i]) begin
                w_accNext[i] = w_sum[i][AccWidth-1:0];
                if (bus.Delay) begin
                    if (w_tick[i] && (r_debt[i] != c_debtMax))
                        w_debtNext[i] = r_debt[i] + c_debtOne;
                end else if (bus.CatchUp[i]) begin
                    if (!w_tick[i] && (r_debt[i] != '0))
                        w_debtNext[i] = r_debt[i] - c_debtOne;
                end else begin
                    w_debtNext[i] = '0;
                end
            end
            if (bus.Delay && w_tick[i] && (r_debt[i] == c_debtMax))
                w_overrunNext[i] = 1'b1;
            else if (bus.ClearOverrun[i])
                w_overrunNext[i] = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_acc     <= '0;
            r_debt    <= '0;
            r_clkEn   <= '0;
            r_overrun <= '0;
        end else begin
            r_acc     <= w_accNext;
            r_debt    <= w_debtNext;
            r_clkEn   <= w_emit;
            r_overrun <= w_overrunNext;
        end
    end

    assign bus.ClkEnOut = r_clkEn;
    assign bus.Debt     = r_debt;
    assign bus.Overrun  = r_overrun;

endmodule

`default_nettype wire
